// File: rtl/otp_stream_sequencer.sv
// One-time-pad stream sequencer: owns the 64-bit keystream LFSR and turns a message of
// plaintext words into cipher words, cipher = ~(plain ^ ks), through a 1-deep output register.
module otp_stream_sequencer #(
    parameter logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF,
    parameter int          LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [63:0]      ks;
    logic [LEN_W-1:0] remaining;
    logic             accept;

    function automatic logic [63:0] ks_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // abort is folded in so a word presented alongside abort is never handshaken
    assign in_ready = (state == RUN) && (remaining != '0) && (!out_valid || out_ready) && !abort;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ks        <= SEED;
            remaining <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load)
                        ks <= (seed_in == 64'd0) ? SEED : seed_in;
                    if (start) begin
                        remaining <= msg_len;
                        word_cnt  <= '0;
                        state     <= (msg_len != '0) ? RUN : DONE;
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        remaining <= '0;
                    end else begin
                        if (accept) begin
                            out_data  <= ~(in_data ^ ks);
                            out_valid <= 1'b1;
                            ks        <= ks_step(ks);
                            remaining <= remaining - 1'b1;
                            word_cnt  <= word_cnt + 1'b1;
                            if (remaining == LEN_W'(1))
                                state <= DRAIN;
                        end else if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                        // DRAIN finishes once the last cipher word has left the register
                        if (state == DRAIN && (!out_valid || out_ready))
                            state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
